// File: rtl/ok_spi_pkg.sv
// Shared definitions for the ok_spi transmit path: FSM encodings and the
// elaboration-time log2 helper used to size counters.
package ok_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// DIV-cycle down-counter: tick is high on the last cycle of each state visit,
// and the count restarts whenever the owning FSM changes state.
module spi_half_tick import ok_spi_pkg::*; #(
    parameter int DIV = 2
) (
    input  logic CLK,
    input  logic rst,
    input  logic reload,
    output logic tick
);

    localparam int CNT_W = clog2(DIV + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload)
            cnt_d = CNT_W'(DIV - 1);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_shift_tx.sv
// Self-timed SPI mode-0 transmit serializer: variable bit count, MSB/LSB
// first, start/busy/done handshake. Every output comes straight from a flop.
module spi_shift_tx import ok_spi_pkg::*; #(
    parameter int WIDTH     = 64,
    parameter int DIV       = 2,
    parameter bit LSB_FIRST = 1'b0,
    parameter int LEN_W     = clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] nbits,
    input  logic [WIDTH-1:0] d_in,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             cs_n,
    output logic             d_out,
    output logic [WIDTH-1:0] debugContents
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] bits_q, bits_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             d_out_q, d_out_d;
    logic             tick;
    logic             reload;

    spi_half_tick #(.DIV(DIV)) u_tick (
        .CLK    (CLK),
        .rst    (rst),
        .reload (reload),
        .tick   (tick)
    );

    assign reload = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && nbits != '0) begin
                    sh_d    = d_in;
                    bits_d  = (nbits > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : nbits;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tick) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (tick) begin
                    bits_d = bits_q - LEN_W'(1);
                    if (bits_q == LEN_W'(1)) begin
                        state_d = ST_HOLD;
                    end else begin
                        // Shifting on the falling edge keeps MOSI stable across SCLK rise.
                        sh_d    = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
                        state_d = ST_LOW;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output flops are loaded from next-state values so they align with state_q.
        cs_n_d  = (state_d == ST_IDLE);
        sclk_d  = (state_d == ST_HIGH);
        busy_d  = !cs_n_d;
        d_out_d = cs_n_d ? 1'b0 : (LSB_FIRST ? sh_d[0] : sh_d[WIDTH-1]);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bits_q  <= '0;
            sh_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            d_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            sh_q    <= sh_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            d_out_q <= d_out_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign sclk          = sclk_q;
    assign cs_n          = cs_n_q;
    assign d_out         = d_out_q;
    assign debugContents = sh_q;

endmodule

// File: tb/tb_spi_shift_tx.sv
// Directed bench for spi_shift_tx: an MSB-first DIV=1 instance and an
// LSB-first DIV=2 instance, MOSI bits scored against a queue on SCLK rises.
module tb_spi_shift_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sel;
    logic [6:0]  nbits;
    logic [63:0] d_in;

    logic        busy0, done0, sclk0, cs_n0, d_out0;
    logic        busy1, done1, sclk1, cs_n1, d_out1;
    logic [63:0] dbg0, dbg1;
    logic        start0, start1;

    logic        busy_o, done_o, sclk_o, cs_n_o, d_out_o;
    logic [63:0] dbg_o;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    assign start0  = start & ~sel;
    assign start1  = start & sel;
    assign busy_o  = sel ? busy1  : busy0;
    assign done_o  = sel ? done1  : done0;
    assign sclk_o  = sel ? sclk1  : sclk0;
    assign cs_n_o  = sel ? cs_n1  : cs_n0;
    assign d_out_o = sel ? d_out1 : d_out0;
    assign dbg_o   = sel ? dbg1   : dbg0;

    spi_shift_tx #(.WIDTH(64), .DIV(1), .LSB_FIRST(1'b0)) u_dut0 (
        .CLK(clk), .rst(rst), .start(start0), .nbits(nbits), .d_in(d_in),
        .busy(busy0), .done(done0), .sclk(sclk0), .cs_n(cs_n0), .d_out(d_out0),
        .debugContents(dbg0)
    );

    spi_shift_tx #(.WIDTH(64), .DIV(2), .LSB_FIRST(1'b1)) u_dut1 (
        .CLK(clk), .rst(rst), .start(start1), .nbits(nbits), .d_in(d_in),
        .busy(busy1), .done(done1), .sclk(sclk1), .cs_n(cs_n1), .d_out(d_out1),
        .debugContents(dbg1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [63:0] exp_dbg);
        check({tag, "_cs_n"},  cs_n_o,  1'b1);
        check({tag, "_sclk"},  sclk_o,  1'b0);
        check({tag, "_d_out"}, d_out_o, 1'b0);
        check({tag, "_busy"},  busy_o,  1'b0);
        check({tag, "_done"},  done_o,  1'b0);
        check({tag, "_dbg"},   dbg_o,   exp_dbg);
    endtask

    // Accept one transfer, score MOSI on each SCLK rise, then check frame timing.
    task automatic run_xfer(input string tag, input logic s, input logic [63:0] data,
                            input int nb, input int n, input int div, input bit lsb);
        int cyc, low, done_at, busy_bad, budget;
        logic prev;
        sel = s; d_in = data; nbits = 7'(nb); start = 1'b1;
        for (int k = 0; k < n; k++) exp_q.push_back(lsb ? data[k] : data[63-k]);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; low = 0; done_at = 0; busy_bad = 0; prev = 1'b0;
        budget = 2 * n * div + div + 10;
        while (cyc <= budget) begin
            if (sclk_o && !prev) begin
                if (exp_q.size() == 0) check({tag, "_extra_bit"}, 1'b1, 1'b0);
                else check($sformatf("%s_bit%0d", tag, n - exp_q.size()), d_out_o, exp_q.pop_front());
            end
            if (!cs_n_o) low++;
            if (busy_o !== !cs_n_o) busy_bad++;
            prev = sclk_o;
            if (done_o) begin
                done_at = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_cs_low_cycles"}, low, 2 * n * div + div);
        check({tag, "_done_cycle"}, done_at, 2 * n * div + div + 1);
        check({tag, "_bits_left"}, exp_q.size(), 0);
        check({tag, "_busy_vs_cs"}, busy_bad, 0);
        exp_q.delete();
    endtask

    initial begin
        int m;
        int bad;
        rst = 1'b1; start = 1'b0; sel = 1'b0; nbits = '0; d_in = '0;
        repeat (2) @(negedge clk);
        check_idle("reset0", 64'h0);
        sel = 1'b1;
        check_idle("reset1", 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // MSB first, DIV=1: 8 bits of A5, final register is the last bit shifted to the top
        run_xfer("msb_a5", 1'b0, 64'hA5 << 56, 8, 8, 1, 1'b0);
        @(negedge clk);
        check_idle("msb_a5_after", 64'h8000_0000_0000_0000);

        // LSB first, DIV=2: bits 1,1,0,0, done at cycle 19
        run_xfer("lsb_3", 1'b1, 64'h3, 4, 4, 2, 1'b1);
        @(negedge clk);
        check_idle("lsb_3_after", 64'h0);

        // nbits=0 is ignored and leaves debugContents alone
        sel = 1'b0; d_in = 64'h1234; nbits = 7'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (busy_o || done_o || !cs_n_o) bad++;
            @(negedge clk);
        end
        check("nbits0_activity", bad, 0);
        check("nbits0_dbg", dbg_o, 64'h8000_0000_0000_0000);

        // nbits beyond WIDTH clamps to 64 bits
        run_xfer("clamp", 1'b0, 64'hDEAD_BEEF_0123_4567, 100, 64, 1, 1'b0);
        @(negedge clk);

        // start held high: 2-bit frames with a single idle cycle between them
        sel = 1'b0; d_in = 64'h8000_0000_0000_0000; nbits = 7'd2; start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            if (c == 18) start = 1'b0;
            @(negedge clk);
            m = c % 6;
            check($sformatf("b2b_cs_n_c%0d", c),  cs_n_o,  m == 0);
            check($sformatf("b2b_done_c%0d", c),  done_o,  m == 0);
            check($sformatf("b2b_sclk_c%0d", c),  sclk_o,  m == 2 || m == 4);
            check($sformatf("b2b_d_out_c%0d", c), d_out_o, m == 1 || m == 2);
        end
        @(negedge clk);
        check("b2b_stopped_cs_n", cs_n_o, 1'b1);

        // Reset in cycle 5 of a 16-bit frame, with a start also raised under reset
        sel = 1'b0; d_in = 64'hFFFF_0000_0000_0000; nbits = 7'd16; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_pre_busy", busy_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_mid", 64'h0);
        start = 1'b1;
        @(negedge clk);
        check("rst_over_start_busy", busy_o, 1'b0);
        rst = 1'b0; start = 1'b0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done_o || busy_o) bad++;
        end
        check("rst_no_done", bad, 0);
        run_xfer("post_rst", 1'b0, 64'h5A5A_0000_0000_0000, 16, 16, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_shift_tx.md
# spi_shift_tx

Parametrised SPI transmit serializer for the `ok_spi` path. It replaces the fixed 64-bit, externally clocked shift-out register with a self-timed transmitter. The block generates SCLK, CS_N and MOSI (SPI mode 0) from the system clock, supports a per-transfer bit count and MSB- or LSB-first order, and uses a start/busy/done handshake. It sits between the host-side register interface and the sensor's serial configuration port.

## Interface
Parameters:
- `WIDTH`, 64: shift register width; max bits per transfer.
- `DIV`, 2: SCLK half-period in CLK cycles; must be ≥1.
- `LSB_FIRST`, 0: 0 = MSB first (`contents[WIDTH-1]` out first), 1 = LSB first.
- `LEN_W`, $clog2(WIDTH+1): width of `nbits`; derived, not overridden.

Ports:
- `CLK` in 1: single clock. One clock; all logic on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `start` in 1: transfer request; sampled only in IDLE.
- `nbits` in LEN_W: bits to send; sampled with `start`.
- `d_in` in WIDTH: parallel word; sampled with `start`.
- `busy` out 1: high from the cycle after acceptance until the `done` cycle, exclusive.
- `done` out 1: one-cycle pulse at transfer end.
- `sclk` out 1: SPI clock; idles low.
- `cs_n` out 1: chip select, active low.
- `d_out` out 1: MOSI.
- `debugContents` out WIDTH: live shift register.

## Operation
- States: IDLE, LOW, HIGH, HOLD. A divider counter counts DIV cycles per state visit. A bit counter holds the remaining bits.
- IDLE outputs: `cs_n`=1, `sclk`=0, `busy`=0, `d_out`=0.
- IDLE + `start`=1 + `nbits`≠0:
  - load `d_in` into the shift register;
  - load the bit counter with min(`nbits`, WIDTH);
  - go to LOW.
- `start` with `nbits`=0 is ignored: no busy, no done.
- LOW: `sclk`=0, `cs_n`=0, for DIV cycles, then go to HIGH.
- HIGH: `sclk`=1, for DIV cycles. At the end, decrement the bit counter.
  - If the counter reaches 0, go to HOLD.
  - Otherwise, shift one place toward the output end (vacated bit filled with 0) and go to LOW.
- HOLD: `sclk`=0, `cs_n`=0, for DIV cycles, then go to IDLE with `done`=1 for that one cycle.
- `d_out` is the output-end bit of the shift register while `cs_n`=0, and 0 otherwise.
  - The output-end bit is `contents[WIDTH-1]` when LSB_FIRST=0 and `contents[0]` when LSB_FIRST=1.
  - MOSI therefore changes only on SCLK falling edges and is stable across each rising edge.
- `start` while not in IDLE is ignored.
- `start` in the `done` cycle is accepted (back-to-back transfers). In that case `cs_n` is high for exactly one cycle between transfers.
- `debugContents` keeps its last value in IDLE. It is overwritten only on acceptance or reset.

## Timing
- Reset values:
  - `cs_n`=1, `sclk`=0, `d_out`=0, `busy`=0, `done`=0;
  - `debugContents`=0;
  - state IDLE, both counters 0.
- `rst` mid-transfer: idle values at the next edge and no `done` pulse. `rst` overrides `start` in the same cycle.
- Let N = effective bit count and acceptance be at edge 0:
  - `cs_n`=0 and `busy`=1 for cycles 1 … 2·N·DIV + DIV;
  - `done`=1 in cycle 2·N·DIV + DIV + 1.
- Bit k (0-based) is on `d_out` for cycles 1+2k·DIV … 2(k+1)·DIV. The rising SCLK edge occurs at cycle 1+(2k+1)·DIV.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `ok_spi_pkg`:
  - state encodings (IDLE=0, LOW=1, HIGH=2, HOLD=3);
  - the `clog2` function used for LEN_W and the divider width.
- Sub-module `spi_half_tick`: a DIV-cycle down-counter producing a `tick` on the last cycle of each state visit, reloaded on every state change. Everything else stays in `spi_shift_tx`.

## Test plan
- WIDTH=64, DIV=1, MSB first, `d_in`=64'hA5<<56, `nbits`=8 → `d_out` 1,0,1,0,0,1,0,1 on 8 rising SCLK edges; `cs_n` low 17 cycles; `done` in cycle 18.
- LSB_FIRST=1, DIV=2, `d_in`=64'h3, `nbits`=4 → bits 1,1,0,0; each SCLK phase 2 cycles; `done` at cycle 19.
- `nbits`=0, then `nbits`=100 → first produces no busy/done; second clamps to 64 bits, with `done` at cycle 2·64·DIV+DIV+1.
- `start` held high continuously with DIV=1, `nbits`=2 → back-to-back transfers with `cs_n` high exactly 1 cycle between them; `start` during busy has no effect.
- `rst` asserted at cycle 5 of a 16-bit transfer → next cycle all outputs at reset values; no `done`; a subsequent `start` behaves normally.
